decoder_scan_nto2n: RTL
=======================

// Module: decoder_scan_nto2n
// PURPOSE
//  Parametrised N-to-2^N line decoder with enable: registered outputs and selectable polarity.
//  Adds an autonomous scan mode that walks the active output through all 2^N lines.
//  Each line is held for DWELL cycles, with optional blanking between lines.
//  Drives digit/row strobes for multiplexed LED and 7-segment displays.
//  Also serves as a registered drop-in for the existing combinational decoders.
// PARAMETERS
//  N           2   select width; 2^N output lines (N >= 1)
//  DWELL       4   scan mode: cycles each line is held active (>= 1)
//  BLANK       1   scan mode: all-inactive cycles inserted before each step (>= 0)
//  ACTIVE_LOW  0   1 = active line driven 0, inactive lines 1
// PORTS
//  Clk   in   1       clock, all state on rising edge
//  Rst   in   1       synchronous reset, active-high
//  En    in   1       enable; 0 forces all outputs inactive
//  Mode  in   1       0 = direct decode of Sel, 1 = autonomous scan
//  Sel   in   N       line select, direct mode only
//  O     out  2^N     decoded lines, registered, O[k] = line k
//  Idx   out  N       index of the line currently selected / scanned
//  Step  out  1       one-cycle pulse in scan mode when Idx advances
// BEHAVIOUR
//  - One clock (Clk). Reset is synchronous and active-high (Rst).
//  - Reset (Rst=1 at edge), overriding all other inputs:
//    - O = all inactive (all 0, or all 1 if ACTIVE_LOW);
//    - Idx = 0, Step = 0;
//    - dwell counter = 0, state = IDLE.
//  - States:
//    - IDLE: En=0.
//    - DIRECT: En=1, Mode=0.
//    - SCAN_ON: active line held.
//    - SCAN_BLANK: inter-line gap.
//  - En=0 (any state):
//    - next edge: O all inactive, Step=0, state IDLE;
//    - Idx and dwell counter hold their values (not cleared).
//  - DIRECT:
//    - latency 1 cycle: O = onehot(Sel) and Idx = Sel at the edge after sampling;
//    - Step = 0 always.
//  - SCAN_ON:
//    - O = onehot(Idx); the counter counts the cycles O has shown this line;
//    - when the count reaches DWELL: if BLANK>0 go to SCAN_BLANK (O all inactive),
//      else step immediately;
//    - no cycle is lost between lines: O shows each line for exactly DWELL cycles.
//  - SCAN_BLANK:
//    - O all inactive for exactly BLANK cycles, then step.
//  - Step action:
//    - Idx <= Idx+1 mod 2^N (3 -> 0 wrap for N=2);
//    - O = onehot(new Idx) and Step = 1 in that same cycle; counter restarts.
//  - Entry into scan (IDLE->scan, or Mode 0->1):
//    - starts in SCAN_ON at the current Idx with the counter cleared;
//    - O valid on the next edge.
//  - Mode 1->0 mid-scan:
//    - next edge decodes Sel; the scan position is abandoned (Idx = Sel).
//  - Enable resume: En 0->1 in scan mode resumes at the held Idx with a fresh dwell.
//  - Sel changes during scan mode are ignored.
//  - Widths:
//    - counter is $clog2(DWELL+BLANK+1) bits and never exceeds DWELL+BLANK;
//    - Idx wraps naturally, no saturation.
//  - Invariants:
//    - exactly one line of O is active whenever state is DIRECT or SCAN_ON;
//    - O is never glitch-combinational: all outputs come from flops.
// TESTING (N=2, DWELL=3, BLANK=1, ACTIVE_LOW=0 unless noted)
//  1. Direct decode:
//     Rst 1 cycle, then En=1, Mode=0, Sel=2 -> next edge O=0100, Idx=2, Step=0.
//     Sel=0 -> O=0001.
//  2. Scan sequence: En=1, Mode=1 from reset ->
//     O=0001 x3, 0000 x1, 0010 (Step=1) x3, 0000, 0100, ...
//     After 1000 the next is 0001 with Idx=0 and Step=1 (wrap).
//  3. Enable gating: En=0 while O=0010 (Idx=1) for 5 cycles -> O=0000 with Idx held at 1.
//     En=1 -> O=0010 for a full 3 cycles.
//  4. Reset mid-scan: Rst=1 during SCAN_BLANK with Idx=2 -> next edge O=0000, Idx=0, Step=0.
//     Release -> scan restarts at 0001.
//  5. Mode switch: Mode 1->0 with Sel=3 during a scan at Idx=1 -> next edge O=1000, Idx=3.
//     Mode back to 1 -> O=1000 for 3 cycles, then blank, then 0001.
//  6. Polarity and no-blank: ACTIVE_LOW=1, BLANK=0, DWELL=1, scan ->
//     O = 1110, 1101, 1011, 0111 on consecutive cycles, with Step=1 on each advance.

Source files
------------

// File: rtl/decoder_scan_nto2n.sv
// N-to-2^N registered line decoder with enable, polarity select and an
// autonomous scan mode that walks the active line with dwell and blanking.
module decoder_scan_nto2n #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Mode,
  input  logic [N-1:0]     Sel,
  output logic [2**N-1:0]  O,
  output logic [N-1:0]     Idx,
  output logic             Step
);

  localparam int L  = 2**N;
  localparam int CW = $clog2(DWELL + BLANK + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN_ON,
    SCAN_BLANK
  } state_e;

  state_e          state_q, state_d;
  logic [L-1:0]    o_q, o_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            step_q, step_d;
  logic [N-1:0]    nxt;
  logic            adv;

  // Polarity is folded in before the flop so O comes straight from a register.
  function automatic logic [L-1:0] lines(
    input logic         act,
    input logic [N-1:0] k
  );
    logic [L-1:0] v;
    v = act ? (L'(1) << k) : '0;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    adv     = 1'b0;
    nxt     = idx_q + N'(1);
    if (!En) begin
      state_d = IDLE;
      o_d     = lines(1'b0, idx_q);
    end else if (!Mode) begin
      state_d = DIRECT;
      o_d     = lines(1'b1, Sel);
      idx_d   = Sel;
    end else begin
      unique case (state_q)
        SCAN_ON: begin
          if (int'(cnt_q) >= DWELL - 1) begin
            if (BLANK > 0) begin
              state_d = SCAN_BLANK;
              o_d     = lines(1'b0, idx_q);
              cnt_d   = '0;
            end else begin
              adv = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SCAN_BLANK: begin
          if (int'(cnt_q) >= BLANK - 1) adv = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
        default: begin
          state_d = SCAN_ON;
          o_d     = lines(1'b1, idx_q);
          cnt_d   = '0;
        end
      endcase
      if (adv) begin
        state_d = SCAN_ON;
        idx_d   = nxt;
        o_d     = lines(1'b1, nxt);
        step_d  = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      o_q     <= lines(1'b0, '0);
      idx_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign O    = o_q;
  assign Idx  = idx_q;
  assign Step = step_q;

endmodule
